// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg: shared FSM state type and default widths for the product accumulator.
package prod_acc_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} prod_acc_state_t;
   localparam int PROD_W_DEF = 8;
   localparam int ACC_W_DEF  = 16;
endpackage

// File: rtl/prod_acc_add.sv
// prod_acc_add: ACC_W add of a zero-extended product, with carry out.
// Define PRODACC_SATURATE_EN to clamp the sum to all-ones on carry instead of wrapping.
module prod_acc_add
   import prod_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [PROD_W-1:0] prod_i,
   output logic [ACC_W-1:0]  sum_o,
   output logic              carry_o
);
   logic [ACC_W:0] wide;
   assign wide    = {1'b0, acc_i} + (ACC_W+1)'(prod_i);
   assign carry_o = wide[ACC_W];
`ifdef PRODACC_SATURATE_EN
   // once clamped, any further nonzero add carries again, so the clamp sticks
   assign sum_o = carry_o ? '1 : wide[ACC_W-1:0];
`else
   assign sum_o = wide[ACC_W-1:0];
`endif
endmodule

// File: rtl/prod_accumulator.sv
// prod_accumulator: reduces a valid/ready stream of products into one sum per job.
// Define PRODACC_SATURATE_EN to saturate the accumulator instead of wrapping.
module prod_accumulator
   import prod_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  sum_out,
   output logic              sum_valid,
   input  logic              sum_ready,
   output logic              busy,
   output logic              overflow
);
   prod_acc_state_t  state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, add_sum;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             ovf_q, ovf_d, add_carry, beat;

   prod_acc_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
      .acc_i  (acc_q),
      .prod_i (prod_in),
      .sum_o  (add_sum),
      .carry_o(add_carry)
   );

   assign prod_ready = state_q == ACCUM;
   assign sum_valid  = state_q == DONE;
   assign busy       = state_q != IDLE;
   assign sum_out    = sum_q;
   assign overflow   = ovf_q;
   assign beat       = prod_valid && prod_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (start) begin
            ovf_d   = 1'b0;
            acc_d   = '0;
            rem_d   = len;
            sum_d   = (len == '0) ? '0 : sum_q;
            state_d = (len == '0) ? DONE : ACCUM;
         end
         ACCUM: if (beat) begin
            acc_d = add_sum;
            rem_d = rem_q - CNT_W'(1);
            ovf_d = ovf_q | add_carry;
            if (rem_q == CNT_W'(1)) begin
               sum_d   = add_sum;
               state_d = DONE;
            end
         end
         DONE: if (sum_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: tb/tb_prod_accumulator.sv
// tb_prod_accumulator: 16-bit and 8-bit accumulators driven in lockstep from shared inputs,
// checked against fixed vectors and a plain-arithmetic model of each job.
module tb_prod_accumulator;
`ifdef PRODACC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, prod_valid = 1'b0, sum_ready = 1'b0;
   logic [7:0]  len = '0, prod_in = '0;
   logic        pr_a, sv_a, busy_a, ov_a, pr_b, sv_b, busy_b, ov_b;
   logic [15:0] so_a;
   logic [7:0]  so_b;
   int          tests = 0, fails = 0;
   int unsigned jp[256];

   typedef struct {
      int              n;
      logic [3:0][7:0] p;
      int              gap;
      int              bp;
      bit              sa;
      bit              sh;
      int unsigned     e16;
      bit              o16;
      int unsigned     e8;
      bit              o8;
   } vec_t;
   vec_t tbl[5];

   always #5 clk = ~clk;

   prod_accumulator dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod_in(prod_in),
      .prod_valid(prod_valid), .prod_ready(pr_a), .sum_out(so_a), .sum_valid(sv_a),
      .sum_ready(sum_ready), .busy(busy_a), .overflow(ov_a)
   );

   prod_accumulator #(.ACC_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod_in(prod_in),
      .prod_valid(prod_valid), .prod_ready(pr_b), .sum_out(so_b), .sum_valid(sv_b),
      .sum_ready(sum_ready), .busy(busy_b), .overflow(ov_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int unsigned mdl(input longint unsigned total, input int w);
      longint unsigned mx;
      mx = (64'd1 << w) - 64'd1;
      return SAT ? int'((total > mx) ? mx : total) : int'(total & mx);
   endfunction

   task automatic chk_both(input string nm, input logic a, input logic b, input logic exp);
      chk({nm, "_a"}, a, exp);
      chk({nm, "_b"}, b, exp);
   endtask

   // drives one job from jp[0..n-1]; gap<0 selects random idle cycles before each beat
   task automatic run_job(input int n, input int gap, input int bp, input bit sa, input bit sh,
                          input int unsigned e16, input bit o16, input int unsigned e8, input bit o8);
      start = 1'b1;
      len   = n[7:0];
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         int g;
         g = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
         for (int k = 0; k < g; k++) begin
            prod_valid = 1'b0;
            prod_in    = 8'($urandom);
            start      = sa;
            len        = 8'd1;
            @(negedge clk);
            chk_both("gap_ready", pr_a, pr_b, 1'b1);
         end
         chk_both("beat_ready", pr_a, pr_b, 1'b1);
         chk_both("early_valid", sv_a, sv_b, 1'b0);
         start      = sa;
         len        = 8'hAA;
         prod_valid = 1'b1;
         prod_in    = jp[i][7:0];
         @(negedge clk);
         prod_valid = 1'b0;
      end
      start = 1'b0;
      chk_both("sum_valid", sv_a, sv_b, 1'b1);
      chk_both("done_ready", pr_a, pr_b, 1'b0);
      chk_both("done_busy", busy_a, busy_b, 1'b1);
      chk("sum16", so_a, e16);
      chk("ovf16", ov_a, o16);
      chk("sum8", so_b, e8);
      chk("ovf8", ov_b, o8);
      for (int k = 0; k < bp; k++) begin
         sum_ready = 1'b0;
         start     = sa;
         @(negedge clk);
         chk_both("hold_valid", sv_a, sv_b, 1'b1);
         chk_both("hold_ready", pr_a, pr_b, 1'b0);
         chk("hold_sum16", so_a, e16);
         chk("hold_sum8", so_b, e8);
         chk("hold_ovf8", ov_b, o8);
      end
      sum_ready = 1'b1;
      start     = sh;
      len       = 8'd3;
      @(negedge clk);
      sum_ready = 1'b0;
      start     = 1'b0;
      chk_both("post_busy", busy_a, busy_b, 1'b0);
      chk_both("post_valid", sv_a, sv_b, 1'b0);
      chk_both("post_ready", pr_a, pr_b, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{3, {8'd0, 8'd225, 8'd0, 8'd35}, 0, 0, 1'b0, 1'b0, 32'd260, 1'b0, SAT ? 32'd255 : 32'd4, 1'b1};
      tbl[1] = '{2, {8'd0, 8'd0, 8'd35, 8'd35}, 2, 5, 1'b1, 1'b1, 32'd70, 1'b0, 32'd70, 1'b0};
      tbl[2] = '{0, {8'd0, 8'd0, 8'd0, 8'd0}, 0, 2, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
      tbl[3] = '{2, {8'd0, 8'd0, 8'd225, 8'd225}, 0, 1, 1'b1, 1'b0, 32'd450, 1'b0, SAT ? 32'd255 : 32'd194, 1'b1};
      tbl[4] = '{1, {8'd0, 8'd0, 8'd0, 8'd35}, 0, 0, 1'b0, 1'b1, 32'd35, 1'b0, 32'd35, 1'b0};

      @(negedge clk);
      chk_both("rst_busy", busy_a, busy_b, 1'b0);
      chk_both("rst_valid", sv_a, sv_b, 1'b0);
      chk_both("rst_ready", pr_a, pr_b, 1'b0);
      chk("rst_sum16", so_a, 0);
      chk_both("rst_ovf", ov_a, ov_b, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 4; k++) jp[k] = tbl[i].p[k];
         run_job(tbl[i].n, tbl[i].gap, tbl[i].bp, tbl[i].sa, tbl[i].sh,
                 tbl[i].e16, tbl[i].o16, tbl[i].e8, tbl[i].o8);
      end

      // asynchronous reset in the middle of a job that already overflowed the 8-bit unit
      start = 1'b1;
      len   = 8'd4;
      @(negedge clk);
      start      = 1'b0;
      prod_valid = 1'b1;
      prod_in    = 8'd225;
      @(negedge clk);
      @(negedge clk);
      prod_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_both("arst_busy", busy_a, busy_b, 1'b0);
      chk_both("arst_valid", sv_a, sv_b, 1'b0);
      chk_both("arst_ready", pr_a, pr_b, 1'b0);
      chk_both("arst_ovf", ov_a, ov_b, 1'b0);
      chk("arst_sum16", so_a, 0);
      chk("arst_sum8", so_b, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      jp[0] = 35;
      run_job(1, 0, 0, 1'b0, 1'b0, 35, 1'b0, 35, 1'b0);

      for (int j = 0; j < 40; j++) begin
         int n;
         longint unsigned total;
         n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 255)) : int'($urandom_range(0, 6));
         total = 0;
         for (int k = 0; k < n; k++) begin
            jp[k] = $urandom_range(0, 15) * $urandom_range(0, 15);
            total += jp[k];
         end
         run_job(n, -1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 mdl(total, 16), total > 65535, mdl(total, 8), total > 255);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
